dft_entry_ctl: RTL and testbench

// - Pin-driven test-mode entry controller for chiptop_1127a0; sits between the TST/SCL/SDA pads and the scan/test muxing.
// - While TST is held high, a 20-bit entry word (16-bit key + 4-bit test select) is clocked in serially on SDA at SCL rising edges.
// - A correct key enables scan mode (ATPG) or an analog test mode; a wrong key is rejected, counted, and locks out entry after MAX_FAIL failures.
// - Downstream: o_scan_mode gates the scan mux and pattern application through the pads.

---
 rtl/dft_entry_ctl.sv | 162 ++++++++++++++++
 tb/tb_dft_entry_ctl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dft_entry_ctl.sv
// Pin-driven test-mode entry controller: debounced TST, serial key/select on SCL/SDA, fail lockout.
// Optional KEY-phase timeout enabled by defining DFT_ENTRY_TIMEOUT_EN.
module dft_entry_ctl #(
    parameter logic [15:0] KEY      = 16'hA5C3,
    parameter int          DEB_CYC  = 4,
    parameter int          MAX_FAIL = 3,
    parameter int          TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       i_tst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scan_mode,
    output logic       o_test_mode,
    output logic [3:0] o_test_sel,
    output logic       o_busy,
    output logic       o_locked,
    output logic [1:0] o_fail_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_ACTIVE, ST_REJECT} state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);
    localparam logic [1:0] FAIL_MAX = 2'(MAX_FAIL);

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    state_t      state_q;
    logic        tst_s1_q, tst_s2_q, scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic        scl_prev_q;
    logic        tst_db_q, tst_db_d;
    logic [3:0]  deb_cnt_q, deb_cnt_d;
    logic [19:0] sr_q;
    logic [4:0]  bcnt_q;
    logic        scl_rise, db_flip, tst_rise, tst_fall, timeout_hit;
    logic [1:0]  fail_inc;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            {tst_s1_q, tst_s2_q, scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q} <= '0;
            scl_prev_q <= 1'b0;
            tst_db_q   <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            tst_s1_q   <= i_tst;
            tst_s2_q   <= tst_s1_q;
            scl_s1_q   <= i_scl;
            scl_s2_q   <= scl_s1_q;
            sda_s1_q   <= i_sda;
            sda_s2_q   <= sda_s1_q;
            scl_prev_q <= scl_s2_q;
            tst_db_q   <= tst_db_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign scl_rise = scl_s2_q & ~scl_prev_q;

    // The level flips on the DEB_CYC-th consecutive differing sample; the FSM sees the edge that same cycle.
    assign db_flip  = (tst_s2_q != tst_db_q) && (deb_cnt_q == DEB_LAST);
    assign tst_rise = db_flip & tst_s2_q;
    assign tst_fall = db_flip & ~tst_s2_q;

    always_comb begin
        tst_db_d  = tst_db_q;
        deb_cnt_d = '0;
        if (db_flip)
            tst_db_d = tst_s2_q;
        else if (tst_s2_q != tst_db_q)
            deb_cnt_d = deb_cnt_q + 4'd1;
    end

`ifdef DFT_ENTRY_TIMEOUT_EN
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);
    logic [12:0] to_cnt_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz)
            to_cnt_q <= '0;
        else if (state_q != ST_KEY)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 13'd1;
    end

    assign timeout_hit = (state_q == ST_KEY) && (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign fail_inc = sat_inc2(o_fail_cnt);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bcnt_q      <= '0;
            o_scan_mode <= 1'b0;
            o_test_mode <= 1'b0;
            o_test_sel  <= '0;
            o_busy      <= 1'b0;
            o_locked    <= 1'b0;
            o_fail_cnt  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tst_rise && !o_locked) begin
                        sr_q    <= '0;
                        bcnt_q  <= '0;
                        o_busy  <= 1'b1;
                        state_q <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    // A TST fall wins over everything, including a completed word.
                    if (tst_fall) begin
                        o_busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bcnt_q == 5'd20) begin
                        o_busy <= 1'b0;
                        if (sr_q[19:4] == KEY) begin
                            o_scan_mode <= (sr_q[3:0] == 4'h0);
                            o_test_mode <= (sr_q[3:0] != 4'h0);
                            o_test_sel  <= sr_q[3:0];
                            state_q     <= ST_ACTIVE;
                        end else begin
                            o_fail_cnt <= fail_inc;
                            if (fail_inc >= FAIL_MAX)
                                o_locked <= 1'b1;
                            state_q <= ST_REJECT;
                        end
                    end else if (timeout_hit) begin
                        o_busy     <= 1'b0;
                        o_fail_cnt <= fail_inc;
                        if (fail_inc >= FAIL_MAX)
                            o_locked <= 1'b1;
                        state_q <= ST_REJECT;
                    end else if (scl_rise) begin
                        sr_q   <= {sr_q[18:0], sda_s2_q};
                        bcnt_q <= bcnt_q + 5'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (tst_fall) begin
                        o_scan_mode <= 1'b0;
                        o_test_mode <= 1'b0;
                        o_test_sel  <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    if (tst_fall)
                        state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dft_entry_ctl.sv
// Directed bench for dft_entry_ctl: expected output vectors queued at stimulus time, popped at check time.
module tb_dft_entry_ctl;

    localparam int DEB_CYC = 4;

    logic       clk = 1'b0;
    logic       rstz;
    logic       i_tst, i_scl, i_sda;
    logic       o_scan_mode, o_test_mode, o_busy, o_locked;
    logic [3:0] o_test_sel;
    logic [1:0] o_fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    dft_entry_ctl dut (
        .clk         (clk),
        .rstz        (rstz),
        .i_tst       (i_tst),
        .i_scl       (i_scl),
        .i_sda       (i_sda),
        .o_scan_mode (o_scan_mode),
        .o_test_mode (o_test_mode),
        .o_test_sel  (o_test_sel),
        .o_busy      (o_busy),
        .o_locked    (o_locked),
        .o_fail_cnt  (o_fail_cnt)
    );

    always #5 clk = ~clk;

    // Vector layout: {scan, test, sel[3:0], busy, locked, fail_cnt[1:0]}
    function automatic logic [9:0] vec(input logic scan, input logic test, input logic [3:0] sel,
                                       input logic busy, input logic locked, input logic [1:0] fc);
        return {scan, test, sel, busy, locked, fc};
    endfunction

    task automatic expect_out(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [9:0] obs, e;
        string      tag;
        obs = {o_scan_mode, o_test_mode, o_test_sel, o_busy, o_locked, o_fail_cnt};
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%b required=%b", tag, obs, e);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        i_sda = b;
        cycles(3);
        i_scl = 1'b1;
        cycles(4);
        i_scl = 1'b0;
        cycles(4);
    endtask

    task automatic shift_bits(input logic [19:0] w, input int n);
        for (int i = 19; i > 19 - n; i--) send_bit(w[i]);
        cycles(4);
    endtask

    task automatic tst_up();
        i_tst = 1'b1;
        cycles(2 + DEB_CYC + 3);
    endtask

    task automatic tst_down();
        i_tst = 1'b0;
        cycles(2 + DEB_CYC + 3);
    endtask

    task automatic do_reset();
        rstz = 1'b0;
        cycles(3);
        rstz = 1'b1;
        cycles(2);
    endtask

    initial begin
        rstz = 1'b0; i_tst = 1'b0; i_scl = 1'b0; i_sda = 1'b0;
        cycles(3);
        expect_out("reset", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();
        rstz = 1'b1;
        cycles(2);

        // T1 scan entry, then TST drop must clear the mode within 2+DEB_CYC cycles
        tst_up();
        expect_out("t1_busy", vec(0, 0, 4'h0, 1, 0, 2'd0));
        check_out();
        shift_bits(20'hA5C30, 20);
        expect_out("t1_scan", vec(1, 0, 4'h0, 0, 0, 2'd0));
        check_out();
        i_tst = 1'b0;
        repeat (2 + DEB_CYC) @(posedge clk);
        @(negedge clk);
        expect_out("t1_exit", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();

        // T2 analog entry
        tst_up();
        shift_bits(20'hA5C35, 20);
        expect_out("t2_analog", vec(0, 1, 4'h5, 0, 0, 2'd0));
        check_out();
        tst_down();
        expect_out("t2_exit", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();

        // T3 bad key three times, then lockout blocks a correct key
        for (int k = 1; k <= 3; k++) begin
            tst_up();
            shift_bits(20'hA5C20, 20);
            expect_out($sformatf("t3_reject%0d", k), vec(0, 0, 4'h0, 0, k == 3, 2'(k)));
            check_out();
            tst_down();
        end
        tst_up();
        expect_out("t3_locked_idle", vec(0, 0, 4'h0, 0, 1, 2'd3));
        check_out();
        shift_bits(20'hA5C30, 20);
        expect_out("t3_locked_key", vec(0, 0, 4'h0, 0, 1, 2'd3));
        check_out();
        tst_down();

        do_reset();
        expect_out("t3_reset_clear", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();

        // T4 abort after 10 bits, then a good entry
        tst_up();
        shift_bits(20'hA5C30, 10);
        tst_down();
        expect_out("t4_abort", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();
        tst_up();
        shift_bits(20'hA5C37, 20);
        expect_out("t4_good", vec(0, 1, 4'h7, 0, 0, 2'd0));
        check_out();

        // T5 SCL activity while ACTIVE must not disturb the select
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        expect_out("t5_scl_active", vec(0, 1, 4'h7, 0, 0, 2'd0));
        check_out();
        tst_down();
        expect_out("t5_exit", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();

        // T5 short TST pulse is filtered
        i_tst = 1'b1;
        repeat (DEB_CYC - 1) @(posedge clk);
        i_tst = 1'b0;
        cycles(12);
        expect_out("t5_glitch", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();

        // T6 rstz mid-KEY drops everything asynchronously
        tst_up();
        shift_bits(20'hA5C30, 5);
        expect_out("t6_midkey", vec(0, 0, 4'h0, 1, 0, 2'd0));
        check_out();
        rstz = 1'b0;
        #1;
        expect_out("t6_async_rst", vec(0, 0, 4'h0, 0, 0, 2'd0));
        check_out();
        i_tst = 1'b0;
        cycles(2);
        rstz = 1'b1;
        cycles(2);

`ifdef DFT_ENTRY_TIMEOUT_EN
        tst_up();
        shift_bits(20'hA5C30, 19);
        cycles(4200);
        expect_out("t6_timeout", vec(0, 0, 4'h0, 0, 0, 2'd1));
        check_out();
        tst_down();
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
